// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core datapath and a byte-enabled word memory.
// It handles one request at a time. A request whose bytes cross a word boundary
// becomes two word accesses. Load data is lane-shifted and extended before it is
// returned over a valid/ready response. The memory strobes, address, data and byte
// enables are decoded from the FSM state only, so an async reset removes them at once.
module lsu_mem_master #(
  parameter int unsigned SPLIT_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Width code is taken from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [7:0] be8_f(input logic [1:0] w, input logic [1:0] off);
    logic [7:0] m;
    case (w)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic cross_f(input logic [1:0] w, input logic [1:0] off);
    logic [2:0] sz;
    case (w)
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return ({1'b0, off} + sz) > 3'd4;
  endfunction

  function automatic logic illegal_f(input logic [2:0] f3, input logic wr, input logic [1:0] off);
    logic bad;
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]);
    if (SPLIT_MISALIGNED == 0) bad = bad || cross_f(f3[1:0], off);
    return bad;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] lo_q, lo_d;
  // The second word only ever supplies its low three bytes, because
  // a crossing access reaches at most three bytes into the next word.
  logic [23:0] hi_q, hi_d;

  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [31:0] base;
  logic [31:0] r;
  logic [31:0] ext;

  assign be8  = be8_f(f3_q[1:0], addr_q[1:0]);
  assign wd64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign base = {addr_q[31:2], 2'b00};

  // Next-state and request/read-data capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    write_d = write_q;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        f3_d    = req_funct3;
        write_d = req_write;
        err_d   = illegal_f(req_funct3, req_write, req_addr[1:0]);
        lo_d    = '0;
        hi_d    = '0;
        state_d = err_d ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        if (!write_q) lo_d = mem_rdata;
        state_d = cross_f(f3_q[1:0], addr_q[1:0]) ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        if (!write_q) hi_d = mem_rdata[23:0];
        state_d = S_RESP;
      end
      default: if (resp_ready) state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight request without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Realign the two captured words so that the addressed byte lands in lane 0.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    r = lo_q;
      2'd1:    r = {hi_q[7:0],  lo_q[31:8]};
      2'd2:    r = {hi_q[15:0], lo_q[31:16]};
      default: r = {hi_q[23:0], lo_q[31:24]};
    endcase
  end

  // Sign or zero extension selected by the width code.
  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{r[7]}}, r[7:0]};
      3'b001:  ext = {{16{r[15]}}, r[15:0]};
      3'b100:  ext = {24'b0, r[7:0]};
      3'b101:  ext = {16'b0, r[15:0]};
      default: ext = r;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? ext : 32'b0;

  // Memory-side outputs are driven in the access states only.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    if (state_q == S_ACC0) begin
      mem_read        = !write_q;
      mem_write       = write_q;
      mem_addr        = base;
      mem_wdata       = wd64[31:0];
      mem_byte_enable = be8[3:0];
    end else if (state_q == S_ACC1) begin
      mem_read        = !write_q;
      mem_write       = write_q;
      mem_addr        = base + 32'd4;
      mem_wdata       = wd64[63:32];
      mem_byte_enable = be8[7:4];
    end
  end

endmodule
